// File: rtl/onehot_req_qualifier.sv
// Qualifies raw request lines into stable one-hot words for a downstream 8-to-3 encoder.
// A pattern must hold for STABLE_CYCLES edges; multi-hot patterns raise a one-cycle Err.
module onehot_req_qualifier #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Req,
  output logic [WIDTH-1:0] Data,
  output logic             Valid,
  input  logic             Ready,
  output logic             Err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    PRESENT  = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     req_q;
  logic [WIDTH-1:0]     snap_q, snap_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // Input stage: one register between the raw lines and the FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= Req;
    end
  end

  // State / output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_q != '0) begin
          state_d = QUAL;
          snap_d  = req_q;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL: begin
        if (req_q == '0) begin
          state_d = IDLE;
        end else if (req_q != snap_q) begin
          snap_d = req_q;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          // Only one-hot words ever reach Data; anything else is reported and dropped
          if (is_onehot(snap_q)) begin
            state_d = PRESENT;
            data_d  = snap_q;
            valid_d = 1'b1;
          end else begin
            state_d = WAIT_REL;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESENT: begin
        if (Ready) begin
          valid_d = 1'b0;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (req_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Data  = data_q;
  assign Valid = valid_q;
  assign Err   = err_q;

endmodule

// File: tb/tb_onehot_req_qualifier.sv
// Bench for onehot_req_qualifier: hand-derived vector table, directed corner sequences,
// and randomized traffic checked against a run-length reference model.
module tb_onehot_req_qualifier;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] Req;
  logic [7:0] Data;
  logic       Valid;
  logic       Ready;
  logic       Err;

  always #5 clk = ~clk;

  onehot_req_qualifier #(.WIDTH(8), .STABLE_CYCLES(S), .CNT_WIDTH(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .Req  (Req),
    .Data (Data),
    .Valid(Valid),
    .Ready(Ready),
    .Err  (Err)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: 0 = listening, 1 = word presented, 2 = blocked until release
  int         m_mode = 0;
  int         m_run  = 0;
  logic [7:0] m_last = '0;
  logic [7:0] m_req  = '0;
  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_err   = 1'b0;

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0; m_run = 0; m_last = '0; m_req = '0;
      m_data = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      case (m_mode)
        0: begin
          if (m_req == 8'h00) m_run = 0;
          else if (m_run > 0 && m_req == m_last) m_run++;
          else begin m_run = 1; m_last = m_req; end
          if (m_run == S) begin
            m_run = 0;
            if ($countones(m_last) == 1) begin
              m_data = m_last; m_valid = 1'b1; m_mode = 1;
            end else begin
              m_err = 1'b1; m_mode = 2;
            end
          end
        end
        1: if (Ready) begin m_valid = 1'b0; m_mode = 2; end
        default: if (m_req == 8'h00) m_mode = 0;
      endcase
      m_req = Req;
    end
  endtask

  task automatic check(input string name, input logic [7:0] dat, input logic vld, input logic er);
    nvec++;
    if (Data !== dat || Valid !== vld || Err !== er || (Valid === 1'b1 && Err === 1'b1)) begin
      nerr++;
      $display("FAIL %s @%0t: got Data=%h Valid=%b Err=%b, required Data=%h Valid=%b Err=%b",
               name, $time, Data, Valid, Err, dat, vld, er);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check({name, "/model"}, m_data, m_valid, m_err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; Req = 8'h00; Ready = 1'b1;
    step("rst"); step("rst");
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       ready;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit saw_valid;

    rst_n = 1'b0; Req = 8'hFF; Ready = 1'b1;

    // Reset with Req=FF, then basic 0x10 and 0x02 presentations with Ready high
    tbl.push_back('{0, 8'hFF, 1, 8'h00, 0, 0});
    tbl.push_back('{0, 8'hFF, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 8'h00, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 8'h10, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 8'h10, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 8'h10, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 8'h10, 1, 8'h00, 0, 0});
    tbl.push_back('{1, 8'h10, 1, 8'h10, 1, 0});
    tbl.push_back('{1, 8'h10, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 8'h10, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 8'h00, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 8'h00, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 8'h02, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 8'h02, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 8'h02, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 8'h02, 1, 8'h10, 0, 0});
    tbl.push_back('{1, 8'h02, 1, 8'h02, 1, 0});
    tbl.push_back('{1, 8'h00, 1, 8'h02, 0, 0});

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; Req = tbl[i].req; Ready = tbl[i].ready;
      step("table");
      check($sformatf("table[%0d]", i), tbl[i].exp_data, tbl[i].exp_valid, tbl[i].exp_err);
    end

    // Backpressure: word held while Ready low, Req changes ignored
    do_reset();
    Req = 8'h01; Ready = 1'b0;
    for (int i = 0; i < 5; i++) step("bp_fill");
    check("bp_present", 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      Req = (i % 2 == 0) ? 8'h80 : 8'h01;
      step("bp_hold");
      check("bp_hold", 8'h01, 1'b1, 1'b0);
    end
    Ready = 1'b1;
    step("bp_accept");
    check("bp_accept", 8'h01, 1'b0, 1'b0);

    // Bounce between 0x04 and 0x08 every 2 edges, then hold 0x08
    do_reset();
    saw_valid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      Req = 8'h04; step("bounce"); step("bounce");
      Req = 8'h08; step("bounce"); step("bounce");
      saw_valid |= Valid;
    end
    check("bounce_quiet", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step("bounce_hold");
      if (Valid) begin
        saw_valid = 1'b1;
        check("bounce_data", 8'h08, 1'b1, 1'b0);
      end
    end
    nvec++;
    if (!saw_valid) begin
      nerr++;
      $display("FAIL bounce_valid: got no Valid, required one presentation of 08");
    end

    // Multi-hot: Err pulse, no re-trigger until Req released
    do_reset();
    Req = 8'h11; Ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step("multi");
      check($sformatf("multi_e%0d", i), 8'h00, 1'b0, i == 5);
    end
    Req = 8'h01;
    for (int i = 0; i < 8; i++) begin
      step("multi_hold");
      check("multi_hold", 8'h00, 1'b0, 1'b0);
    end
    Req = 8'h00; step("multi_rel"); step("multi_rel");
    Req = 8'h01;
    for (int i = 0; i < 5; i++) step("multi_new");
    check("multi_new", 8'h01, 1'b1, 1'b0);

    // Reset while a word is presented
    do_reset();
    Req = 8'h40; Ready = 1'b0;
    for (int i = 0; i < 6; i++) step("rp_fill");
    check("rp_present", 8'h40, 1'b1, 1'b0);
    rst_n = 1'b0;
    step("rp_reset");
    check("rp_reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step("rp_requal");
      check($sformatf("rp_requal_e%0d", i), (i == 5) ? 8'h40 : 8'h00, i == 5, 1'b0);
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int seg = 0; seg < 400; seg++) begin
      int sel;
      int len;
      sel = $urandom_range(0, 9);
      if (sel < 3)      Req = 8'h00;
      else if (sel < 8) Req = 8'h01 << $urandom_range(0, 7);
      else              Req = 8'($urandom);
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        Ready = ($urandom_range(0, 3) != 0);
        rst_n = ($urandom_range(0, 199) != 0);
        step("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
